// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the forwarding/hazard logic: the shadow-slot
// record, the operand-mux select encodings, and the hard-wired zero register.
package pipeline_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A slot supplies a source only if the source is really read and is not r0.
    function automatic logic slot_hits(input slot_t slot, input logic [4:0] src,
                                       input logic uses);
        return uses && (src != REG_ZERO) && slot.valid && (slot.rd == src);
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Per-operand comparator: chooses the forwarding source for one source
// register and flags a dependency on a load that is still in the ex slot.
module hazard_compare
    import pipeline_pkg::*;
(
    input  logic [4:0] src,
    input  logic       uses,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    output logic [1:0] sel,
    output logic       load_hit
);

    logic hit_ex;
    logic hit_mem;
    logic unused_mem_is_load;

    assign hit_ex   = slot_hits(ex_slot, src, uses);
    assign hit_mem  = slot_hits(mem_slot, src, uses);
    assign load_hit = hit_ex & ex_slot.is_load;

    // A load in the mem slot forwards like any other result.
    assign unused_mem_is_load = mem_slot.is_load;

    // NOTE: every output gets a default first so no path through the block
    // leaves sel unassigned and infers a latch.
    always_comb begin
        sel = FWD_REGFILE;
        if (hit_ex)
            sel = FWD_MEM;
        else if (hit_mem)
            sel = FWD_WB;
    end

endmodule

// File: rtl/forward_control.sv
// Forwarding and load-use interlock control: tracks the destinations of the
// three instructions ahead of decode and registers the EX operand selects.
module forward_control
    import pipeline_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rs,
    input  logic [4:0]         issue_rt,
    input  logic               issue_uses_rs,
    input  logic               issue_uses_rt,
    input  logic [4:0]         issue_rd,
    input  logic               issue_writes,
    input  logic               issue_is_load,
    input  logic               flush,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               stall,
    output logic [COUNT_W-1:0] stall_count
);

    slot_t      issue_slot;
    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      wb_slot;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_hit_a;
    logic       load_hit_b;
    logic       advance;
    logic       unused_wb;

    assign issue_slot.valid   = issue_valid & issue_writes & (issue_rd != REG_ZERO);
    assign issue_slot.rd      = issue_rd;
    assign issue_slot.is_load = issue_is_load;

    hazard_compare u_cmp_a (
        .src      (issue_rs),
        .uses     (issue_uses_rs),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_a),
        .load_hit (load_hit_a)
    );

    hazard_compare u_cmp_b (
        .src      (issue_rt),
        .uses     (issue_uses_rt),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_b),
        .load_hit (load_hit_b)
    );

    // The interlock looks only at the ex slot, never at the registered selects.
    assign stall   = issue_valid & (load_hit_a | load_hit_b);
    assign advance = issue_valid & ~stall & ~flush;

    // The wb slot mirrors the write-back stage; nothing forwards from it yet.
    assign unused_wb = ^wb_slot;

    // NOTE: non-blocking assignments let wb and mem sample the pre-edge values
    // of the slot ahead, so the shift works regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            fwd_a_sel <= FWD_REGFILE;
            fwd_b_sel <= FWD_REGFILE;
        end else begin
            wb_slot   <= mem_slot;
            mem_slot  <= ex_slot;
            ex_slot   <= advance ? issue_slot : '0;
            fwd_a_sel <= advance ? sel_a : FWD_REGFILE;
            fwd_b_sel <= advance ? sel_b : FWD_REGFILE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_forward_control.sv
// Self-checking bench for forward_control: a table of issue vectors with
// expected selects queued on drive and popped after the EX edge, plus
// hand-written reset and counter-saturation sequences.
module tb_forward_control;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       issue_valid;
    logic [4:0] issue_rs;
    logic [4:0] issue_rt;
    logic       issue_uses_rs;
    logic       issue_uses_rt;
    logic [4:0] issue_rd;
    logic       issue_writes;
    logic       issue_is_load;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic [15:0] stall_count;
    logic [1:0] sat_a_sel;
    logic [1:0] sat_b_sel;
    logic       sat_stall;
    logic [3:0] sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       exp_stall;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    forward_control dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rs (issue_uses_rs),
        .issue_uses_rt (issue_uses_rt),
        .issue_rd      (issue_rd),
        .issue_writes  (issue_writes),
        .issue_is_load (issue_is_load),
        .flush         (flush),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .stall         (stall),
        .stall_count   (stall_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    forward_control #(.COUNT_W(4)) dut_sat (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rs (issue_uses_rs),
        .issue_uses_rt (issue_uses_rt),
        .issue_rd      (issue_rd),
        .issue_writes  (issue_writes),
        .issue_is_load (issue_is_load),
        .flush         (flush),
        .fwd_a_sel     (sat_a_sel),
        .fwd_b_sel     (sat_b_sel),
        .stall         (sat_stall),
        .stall_count   (sat_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string n, input logic v,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [4:0] rd, input logic wr,
                                input logic ld, input logic fl,
                                input logic st, input logic [1:0] a,
                                input logic [1:0] b);
        vec_t x;
        x.name = n; x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.rd = rd; x.wr = wr; x.ld = ld; x.fl = fl;
        x.exp_stall = st; x.exp_a = a; x.exp_b = b;
        return x;
    endfunction

    function automatic vec_t nop();
        return mk("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endfunction

    task automatic drive(input vec_t x);
        issue_valid   = x.v;
        issue_rs      = x.rs;
        issue_rt      = x.rt;
        issue_uses_rs = x.urs;
        issue_uses_rt = x.urt;
        issue_rd      = x.rd;
        issue_writes  = x.wr;
        issue_is_load = x.ld;
        flush         = x.fl;
    endtask

    // Drive one vector, check stall before the edge, check selects after it.
    task automatic apply(input vec_t x);
        exp_t e;
        drive(x);
        #1;
        check({x.name, ":stall"}, {31'd0, stall}, {31'd0, x.exp_stall});
        sb.push_back('{name: x.name, a: x.exp_a, b: x.exp_b});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({e.name, ":fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, e.a});
        check({e.name, ":fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, e.b});
    endtask

    initial begin
        int exp_stalls;
        drive(nop());
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset:fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        check("reset:fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        check("reset:count", {16'd0, stall_count}, 32'd0);
        check("reset:sat_count", {28'd0, sat_count}, 32'd0);

        // Clock with live issue traffic while reset is held: nothing may load.
        drive(mk("rst_traffic", 1, 3, 3, 1, 1, 3, 1, 1, 0, 0, 2'b00, 2'b00));
        #1 check("reset:stall", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_held:fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        check("reset_held:stall", {31'd0, stall}, 32'd0);
        check("reset_held:count", {16'd0, stall_count}, 32'd0);
        drive(nop());
        reset_n = 1'b1;

        //            name           v  rs  rt urs urt rd wr ld fl st  a      b
        tbl.push_back(mk("alu_r3",     1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("alu_fwd_r3", 1,  3,  4, 1, 1,  5, 1, 0, 0, 0, 2'b01, 2'b00));
        tbl.push_back(nop()); tbl.push_back(nop());
        tbl.push_back(mk("d2_r3",      1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("d2_unrel",   1, 11, 12, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("d2_r3r3",    1,  3,  3, 1, 1,  6, 1, 0, 0, 0, 2'b10, 2'b10));
        tbl.push_back(nop()); tbl.push_back(nop());
        tbl.push_back(mk("y_r7a",      1,  1,  1, 1, 1,  7, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("y_r7b",      1,  2,  2, 1, 1,  7, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("y_read7",    1,  7,  0, 1, 1,  8, 1, 0, 0, 0, 2'b01, 2'b00));
        tbl.push_back(mk("y_read7b",   1,  1,  7, 1, 1,  9, 1, 0, 0, 0, 2'b00, 2'b10));
        tbl.push_back(nop()); tbl.push_back(nop());
        tbl.push_back(mk("lu_lw8",     1,  1,  0, 1, 0,  8, 1, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("lu_stall",   1,  8,  1, 1, 1,  9, 1, 0, 0, 1, 2'b00, 2'b00));
        tbl.push_back(mk("lu_retry",   1,  8,  1, 1, 1,  9, 1, 0, 0, 0, 2'b10, 2'b00));
        tbl.push_back(mk("lu_lw12",    1,  2,  0, 1, 0, 12, 1, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("lu_stall_b", 1,  2, 12, 1, 1, 13, 1, 0, 0, 1, 2'b00, 2'b00));
        tbl.push_back(mk("lu_retry_b", 1,  2, 12, 1, 1, 13, 1, 0, 0, 0, 2'b00, 2'b10));
        tbl.push_back(nop()); tbl.push_back(nop());
        tbl.push_back(mk("z_w_r0",     1,  1,  2, 1, 1,  0, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("z_read_r0",  1,  0,  0, 1, 1,  4, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("u_w5",       1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("u_nouse",    1,  5,  5, 0, 0,  6, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("u_lw10",     1,  1,  0, 1, 0, 10, 1, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("u_lw_nouse", 1, 10, 10, 0, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(nop()); tbl.push_back(nop());
        tbl.push_back(mk("f_lw14",     1,  1,  0, 1, 0, 14, 1, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("f_flush_lu", 1, 14,  1, 1, 1, 15, 1, 0, 1, 1, 2'b00, 2'b00));
        tbl.push_back(mk("f_after",    1, 14, 15, 1, 1, 16, 1, 0, 0, 0, 2'b10, 2'b00));
        tbl.push_back(mk("f_flush_w",  1, 16,  2, 1, 1, 17, 1, 0, 1, 0, 2'b00, 2'b00));
        tbl.push_back(mk("f_read17",   1, 17, 17, 1, 1, 18, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(nop());
        tbl.push_back(mk("f_read17b",  1, 17,  1, 1, 1, 19, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(nop()); tbl.push_back(nop());
        tbl.push_back(mk("iv_w20",     1,  1,  2, 1, 1, 20, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("iv_inval",   0, 20, 20, 1, 1, 21, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("iv_lw21",    1,  1,  0, 1, 0, 21, 1, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("iv_inv_lu",  0, 21,  0, 1, 0, 22, 1, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk("iv_read21",  1, 21, 20, 1, 1, 23, 1, 0, 0, 0, 2'b10, 2'b00));
        tbl.push_back(nop()); tbl.push_back(nop());

        exp_stalls = 0;
        foreach (tbl[i]) begin
            if (tbl[i].exp_stall) exp_stalls++;
            apply(tbl[i]);
        end
        check("table:count", {16'd0, stall_count}, exp_stalls);
        check("table:sat_count", {28'd0, sat_count}, exp_stalls);

        // Mid-stream asynchronous reset with a forward and a stall in flight.
        drive(mk("m_w3", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00));
        @(posedge clock); #1;
        drive(mk("m_lw8", 1, 3, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00));
        @(posedge clock); #1;
        check("mid:pre_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
        drive(mk("m_use8", 1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00));
        #1 check("mid:pre_stall", {31'd0, stall}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid:rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        check("mid:rst_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        check("mid:rst_stall", {31'd0, stall}, 32'd0);
        check("mid:rst_count", {16'd0, stall_count}, 32'd0);
        check("mid:rst_sat_count", {28'd0, sat_count}, 32'd0);
        @(posedge clock); #1;
        check("mid:held_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        reset_n = 1'b1;
        #1 check("mid:first_stall", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        check("mid:first_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        check("mid:first_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        drive(nop());
        repeat (2) @(posedge clock);
        #1;

        // Repeated load-use pairs: one stall every two cycles.
        for (int i = 0; i < 20; i++) begin
            drive(mk("s_lw1", 1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00));
            @(posedge clock); #1;
            drive(mk("s_use1", 1, 1, 1, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00));
            #1;
            check($sformatf("sat%0d:stall", i), {31'd0, stall}, 32'd1);
            check($sformatf("sat%0d:sat_stall", i), {31'd0, sat_stall}, 32'd1);
            @(posedge clock); #1;
            check($sformatf("sat%0d:count", i), {16'd0, stall_count}, i + 1);
            check($sformatf("sat%0d:sat_count", i), {28'd0, sat_count},
                  (i + 1 > 15) ? 15 : i + 1);
        end
        drive(nop());

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_control.md
FORWARD_CONTROL -- requirements
Module: forward_control

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clock  in  1  single rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode stage presents an instruction this cycle
- issue_rs  in  5  source register A of the issuing instruction
- issue_rt  in  5  source register B of the issuing instruction
- issue_uses_rs  in  1  instruction reads rs
- issue_uses_rt  in  1  instruction reads rt
- issue_rd  in  5  destination register of the issuing instruction
- issue_writes  in  1  instruction writes rd
- issue_is_load  in  1  instruction is a load (result is available at WB only)
- flush  in  1  squash the instruction entering EX this cycle
- fwd_a_sel  out  2  registered EX-stage operand-A mux select
- fwd_b_sel  out  2  registered EX-stage operand-B mux select
- stall  out  1  combinational load-use stall request to fetch/decode
- stall_count  out  16  saturating count of stall cycles
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.

Function
REQ-003 The block SHALL keep three shadow slots (ex, mem, wb), each holding {valid, rd[4:0], is_load}.
REQ-004 Slot load value: valid = issue_valid & issue_writes & (issue_rd != 0).
REQ-005 On every rising edge: wb <= mem; mem <= ex. The ex slot takes the issue-slot value only when stall=0 and flush=0; otherwise it takes a bubble (valid=0).
REQ-006 Select encoding: 2'b00 = register file; 2'b01 = MEM-stage result (the instruction currently in the ex slot); 2'b10 = WB-stage result (the instruction currently in the mem slot); 2'b11 SHALL never be driven.
REQ-007 fwd_a_sel is registered. It SHALL be computed from the issuing instruction (rs, uses_rs) and SHALL appear exactly 1 cycle after issue, aligned with that instruction's EX cycle.
REQ-008 fwd_b_sel SHALL be computed the same way as fwd_a_sel, using rt and uses_rt.
REQ-009 Priority when both slots match: the ex slot (younger) SHALL win over the mem slot.
REQ-010 A source register of 0, or a cleared uses_* flag, SHALL always yield 2'b00.
REQ-011 stall=1 iff all of the following hold: issue_valid=1; ex slot valid with is_load=1; and its rd equals a used nonzero source of the issuing instruction.
REQ-012 During stall, or when flush=1, or when issue_valid=0, the registered selects SHALL load 2'b00 for the bubble.
REQ-013 If flush and a stall condition coincide, flush SHALL win for the ex slot (bubble). stall still reflects REQ-011.
REQ-014 A load in the mem slot SHALL forward with 2'b10; its data is valid at that point.
REQ-015 stall_count SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-016 stall SHALL be purely combinational from the inputs and the ex slot, with no dependence on the selects.

Reset
REQ-017 While reset_n=0, regardless of clock, the block SHALL hold: all slots valid=0, fwd_a_sel=fwd_b_sel=2'b00, stall_count=0.
REQ-018 stall SHALL read 0 throughout reset, because the ex slot is invalid.
REQ-019 Deasserting reset mid-program SHALL leave no stale forwarding: the first issued instruction receives 2'b00 selects.

Structure
REQ-020 The shared package pipeline_pkg SHALL hold:
- the slot record typedef
- constants FWD_REGFILE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
- REG_ZERO=5'd0
REQ-021 A single sub-module, hazard_compare, SHALL be instantiated once per operand. It takes src, uses, ex slot and mem slot, and returns the 2-bit select and a load-hit flag. It SHALL be combinational.
REQ-022 Total RTL SHALL stay within 120-400 lines; no other sub-modules.

Verification
REQ-023 Back-to-back ALU: issue r3<-r1+r2, then r5<-r3+r4 -> cycle 2 fwd_a_sel=01, fwd_b_sel=00, stall=0.
REQ-024 Distance two: r3<-..., an unrelated instruction, then r6<-r3+r3 -> fwd_a_sel=fwd_b_sel=10.
REQ-025 Both slots write r7: issue a reader of r7 -> select=01 (younger wins).
REQ-026 Load-use: lw r8, then add r9<-r8+r1 -> stall=1 for exactly one cycle, bubble selects 00; on retry fwd_a_sel=10; stall_count=1.
REQ-027 Writes to r0, and flush coinciding with a load-use -> selects remain 00, ex slot is a bubble, no forward from the squashed instruction.
REQ-028 Reset and saturation: assert reset_n=0 asynchronously mid-stream -> outputs 00 and count 0 immediately; force 65536 stalls -> stall_count holds 16'hFFFF.
